// File: rtl/riscv_sb_pkg.sv
// Shared types for the forwarding scoreboard: one slot per in-flight instruction.
// Register addresses are zero-extended into SB_ADDR_W-bit fields.
package riscv_sb_pkg;

    localparam int unsigned SB_ADDR_W = 8;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 isLoad;
        logic [SB_ADDR_W-1:0] rd;
        logic [SB_ADDR_W-1:0] rs1;
        logic [SB_ADDR_W-1:0] rs2;
        logic                 useRs1;
        logic                 useRs2;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    function automatic logic isProducer(sb_entry_t e);
        return e.valid && e.regwrite && (e.rd != '0);
    endfunction

endpackage

// File: rtl/riscv_fwd_select.sv
// One-operand forwarding matcher: youngest ready producer of src wins, else register file.
// unreadyHit flags a match on a load whose data is not yet valid.
module riscv_fwd_select
    import riscv_sb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NUM_FWD_STAGES = 2,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned SEL_W = 2
) (
    input  logic [SB_ADDR_W-1:0]           src,
    input  logic                           useSrc,
    input  sb_entry_t [NUM_FWD_STAGES:1]   pipe,
    input  logic [NUM_FWD_STAGES*XLEN-1:0] resultData,
    input  logic [XLEN-1:0]                rfData,
    output logic [XLEN-1:0]                data,
    output logic [SEL_W-1:0]               sel,
    output logic                           unreadyHit
);

    logic unusedFields;

    // Scan oldest to youngest so the youngest ready match is the last to assign.
    always_comb begin
        data         = rfData;
        sel          = '0;
        unreadyHit   = 1'b0;
        unusedFields = 1'b0;
        for (int unsigned j = NUM_FWD_STAGES; j >= 1; j--) begin
            unusedFields = unusedFields ^ (^{pipe[j].rs1, pipe[j].rs2,
                                             pipe[j].useRs1, pipe[j].useRs2});
            if (useSrc && (src != '0) && isProducer(pipe[j]) && (pipe[j].rd == src)) begin
                if (!pipe[j].isLoad || (j > LOAD_LATENCY)) begin
                    data = resultData[(j-1)*XLEN +: XLEN];
                    sel  = SEL_W'(j);
                end else begin
                    unreadyHit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/riscv_forwarding_scoreboard.sv
// Hazard/forwarding scoreboard tracking destinations from EX to WB; load-use stall and operand bypass.
// Define RISCV_SB_PERF_EN to add saturating stall_count and fwd_count outputs.
module riscv_forwarding_scoreboard
    import riscv_sb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_FWD_STAGES = 2,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned FLUSH_DEPTH = 2,
    localparam int unsigned SEL_W = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  logic [REG_ADDR_W-1:0]          issue_rd,
    input  logic                           issue_regwrite,
    input  logic                           issue_is_load,
    input  logic [REG_ADDR_W-1:0]          issue_rs1,
    input  logic [REG_ADDR_W-1:0]          issue_rs2,
    input  logic                           issue_use_rs1,
    input  logic                           issue_use_rs2,
    input  logic                           flush,
    input  logic [NUM_FWD_STAGES*XLEN-1:0] result_data,
    input  logic [XLEN-1:0]                rf_data1,
    input  logic [XLEN-1:0]                rf_data2,
    output logic                           stall,
    output logic [XLEN-1:0]                ex_op1,
    output logic [XLEN-1:0]                ex_op2,
    output logic [SEL_W-1:0]               fwd_sel1,
    output logic [SEL_W-1:0]               fwd_sel2
`ifdef RISCV_SB_PERF_EN
    ,
    output logic [31:0]                    stall_count,
    output logic [31:0]                    fwd_count
`endif
);

    sb_entry_t [NUM_FWD_STAGES:0] pipeQ;
    sb_entry_t [NUM_FWD_STAGES:0] pipeD;
    sb_entry_t                    issueEntry;
    logic [SB_ADDR_W-1:0]         issueRs1;
    logic [SB_ADDR_W-1:0]         issueRs2;
    logic                         loadHit;
    logic                         unready1;
    logic                         unready2;
    logic                         unusedWbSrc;

    assign issueRs1 = SB_ADDR_W'(issue_rs1);
    assign issueRs2 = SB_ADDR_W'(issue_rs2);

    always_comb begin
        issueEntry          = SB_BUBBLE;
        issueEntry.valid    = 1'b1;
        issueEntry.regwrite = issue_regwrite;
        issueEntry.isLoad   = issue_is_load;
        issueEntry.rd       = SB_ADDR_W'(issue_rd);
        issueEntry.rs1      = issueRs1;
        issueEntry.rs2      = issueRs2;
        issueEntry.useRs1   = issue_use_rs1;
        issueEntry.useRs2   = issue_use_rs2;
    end

    // A load in the first LOAD_LATENCY slots cannot yet supply its data to the ID consumer.
    always_comb begin
        loadHit = 1'b0;
        for (int unsigned k = 0; k < LOAD_LATENCY; k++) begin
            if (isProducer(pipeQ[k]) && pipeQ[k].isLoad &&
                ((issue_use_rs1 && (issueRs1 == pipeQ[k].rd)) ||
                 (issue_use_rs2 && (issueRs2 == pipeQ[k].rd)))) begin
                loadHit = 1'b1;
            end
        end
    end

    assign stall = issue_valid && loadHit && !flush;

    always_comb begin
        pipeD = pipeQ;
        if (issue_valid && !stall && !flush) begin
            pipeD[0] = issueEntry;
        end else begin
            pipeD[0] = SB_BUBBLE;
        end
        for (int unsigned k = 1; k <= NUM_FWD_STAGES; k++) begin
            pipeD[k] = (flush && (k < FLUSH_DEPTH)) ? SB_BUBBLE : pipeQ[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= NUM_FWD_STAGES; k++) begin
                pipeQ[k] <= SB_BUBBLE;
            end
        end else begin
            pipeQ <= pipeD;
        end
    end

    riscv_fwd_select #(
        .XLEN          (XLEN),
        .NUM_FWD_STAGES(NUM_FWD_STAGES),
        .LOAD_LATENCY  (LOAD_LATENCY),
        .SEL_W         (SEL_W)
    ) uFwd1 (
        .src       (pipeQ[0].rs1),
        .useSrc    (pipeQ[0].valid && pipeQ[0].useRs1),
        .pipe      (pipeQ[NUM_FWD_STAGES:1]),
        .resultData(result_data),
        .rfData    (rf_data1),
        .data      (ex_op1),
        .sel       (fwd_sel1),
        .unreadyHit(unready1)
    );

    riscv_fwd_select #(
        .XLEN          (XLEN),
        .NUM_FWD_STAGES(NUM_FWD_STAGES),
        .LOAD_LATENCY  (LOAD_LATENCY),
        .SEL_W         (SEL_W)
    ) uFwd2 (
        .src       (pipeQ[0].rs2),
        .useSrc    (pipeQ[0].valid && pipeQ[0].useRs2),
        .pipe      (pipeQ[NUM_FWD_STAGES:1]),
        .resultData(result_data),
        .rfData    (rf_data2),
        .data      (ex_op2),
        .sel       (fwd_sel2),
        .unreadyHit(unready2)
    );

    // The WB slot's source fields are carried only to keep the slot format uniform.
    assign unusedWbSrc = ^{pipeQ[NUM_FWD_STAGES].rs1, pipeQ[NUM_FWD_STAGES].rs2,
                           pipeQ[NUM_FWD_STAGES].useRs1, pipeQ[NUM_FWD_STAGES].useRs2};

    // The load-use stall should make an unready match in EX unreachable.
    assert property (@(posedge clk) disable iff (rst) !(unready1 || unready2));

`ifdef RISCV_SB_PERF_EN
    logic fwdActive;
    assign fwdActive = pipeQ[0].valid && ((fwd_sel1 != '0) || (fwd_sel2 != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (fwdActive && (fwd_count != 32'hFFFF_FFFF)) begin
                fwd_count <= fwd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_forwarding_scoreboard.sv
// Directed bench: vector table on the default 2-stage/LL=1 build, plus flush,
// mid-run reset and a 3-stage/LL=2 load-use sequence.
module tb_riscv_forwarding_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_regwrite;
    logic        issue_is_load;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic        flush;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [63:0] resA;
    logic [95:0] resB;

    logic        stallA, stallB;
    logic [31:0] op1A, op2A, op1B, op2B;
    logic [1:0]  sel1A, sel2A, sel1B, sel2B;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_forwarding_scoreboard dutA (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_regwrite(issue_regwrite),
        .issue_is_load (issue_is_load),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .flush         (flush),
        .result_data   (resA),
        .rf_data1      (rf1),
        .rf_data2      (rf2),
        .stall         (stallA),
        .ex_op1        (op1A),
        .ex_op2        (op2A),
        .fwd_sel1      (sel1A),
        .fwd_sel2      (sel2A)
    );

    riscv_forwarding_scoreboard #(
        .NUM_FWD_STAGES(3),
        .LOAD_LATENCY  (2),
        .FLUSH_DEPTH   (2)
    ) dutB (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_regwrite(issue_regwrite),
        .issue_is_load (issue_is_load),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .flush         (flush),
        .result_data   (resB),
        .rf_data1      (rf1),
        .rf_data2      (rf2),
        .stall         (stallB),
        .ex_op1        (op1B),
        .ex_op2        (op2B),
        .fwd_sel1      (sel1B),
        .fwd_sel2      (sel2B)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        eStall;
        logic [1:0]  eSel1;
        logic [1:0]  eSel2;
        logic [31:0] eOp1;
        logic [31:0] eOp2;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic v, logic [4:0] rd, logic rw, logic ld,
                                logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [31:0] f1, logic [31:0] f2, logic [31:0] r1,
                                logic [31:0] r2, logic st, logic [1:0] s1, logic [1:0] s2,
                                logic [31:0] o1, logic [31:0] o2);
        vec_t x;
        x.v = v; x.rd = rd; x.rw = rw; x.ld = ld; x.rs1 = rs1; x.rs2 = rs2;
        x.u1 = u1; x.u2 = u2; x.rf1 = f1; x.rf2 = f2; x.r1 = r1; x.r2 = r2;
        x.eStall = st; x.eSel1 = s1; x.eSel2 = s2; x.eOp1 = o1; x.eOp2 = o2;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic ld,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        issue_valid    = v;
        issue_rd       = rd;
        issue_regwrite = v;
        issue_is_load  = ld;
        issue_rs1      = rs1;
        issue_rs2      = rs2;
        issue_use_rs1  = u1;
        issue_use_rs2  = u2;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int nStall;

    initial begin
        rst  = 1'b1;
        flush = 1'b0;
        rf1  = 32'h100;
        rf2  = 32'h200;
        resA = '0;
        resB = '0;
        issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);

        //               v rd  rw ld rs1 rs2 u1 u2 rf1     rf2     r1          r2          st s1 s2 op1         op2
        vecs[0]  = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[1]  = mk(1, 5,  1, 1, 1,  0,  1, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[2]  = mk(1, 6,  1, 0, 5,  7,  1, 1, 32'h100, 32'h200, 32'h55,     32'hAA,     1, 0, 0, 32'h100,    32'h200);
        vecs[3]  = mk(1, 6,  1, 0, 5,  7,  1, 1, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[4]  = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 2, 0, 32'hAA,     32'h200);
        vecs[5]  = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[6]  = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[7]  = mk(1, 1,  1, 0, 0,  0,  1, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[8]  = mk(1, 2,  1, 0, 1,  1,  1, 1, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[9]  = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h5,      32'hAA,     0, 1, 1, 32'h5,      32'h5);
        vecs[10] = mk(1, 3,  1, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[11] = mk(1, 3,  1, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[12] = mk(1, 4,  1, 0, 3,  3,  1, 1, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[13] = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h11,     32'h22,     0, 1, 1, 32'h11,     32'h11);
        vecs[14] = mk(1, 0,  1, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[15] = mk(1, 8,  1, 0, 0,  0,  1, 1, 32'h0,   32'h0,   32'h55,     32'hAA,     0, 0, 0, 32'h0,      32'h0);
        vecs[16] = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h0,   32'h0,   32'hDEAD,   32'hBEEF,   0, 0, 0, 32'h0,      32'h0);
        vecs[17] = mk(1, 9,  1, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[18] = mk(1, 11, 1, 0, 9,  9,  0, 1, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[19] = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 1, 32'h100,    32'h55);
        vecs[20] = mk(1, 10, 1, 1, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[21] = mk(1, 12, 1, 0, 10, 0,  0, 1, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);
        vecs[22] = mk(0, 0,  0, 0, 0,  0,  0, 0, 32'h100, 32'h200, 32'h55,     32'hAA,     0, 0, 0, 32'h100,    32'h200);

        doReset();

        // Each row: drive at negedge, sample combinational outputs 1 ns later.
        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) @(negedge clk);
            issue_valid    = vecs[i].v;
            issue_rd       = vecs[i].rd;
            issue_regwrite = vecs[i].rw;
            issue_is_load  = vecs[i].ld;
            issue_rs1      = vecs[i].rs1;
            issue_rs2      = vecs[i].rs2;
            issue_use_rs1  = vecs[i].u1;
            issue_use_rs2  = vecs[i].u2;
            rf1            = vecs[i].rf1;
            rf2            = vecs[i].rf2;
            resA           = {vecs[i].r2, vecs[i].r1};
            #1;
            check($sformatf("vec%0d stall", i), {31'd0, stallA}, {31'd0, vecs[i].eStall});
            check($sformatf("vec%0d sel1", i), {30'd0, sel1A}, {30'd0, vecs[i].eSel1});
            check($sformatf("vec%0d sel2", i), {30'd0, sel2A}, {30'd0, vecs[i].eSel2});
            check($sformatf("vec%0d op1", i), op1A, vecs[i].eOp1);
            check($sformatf("vec%0d op2", i), op2A, vecs[i].eOp2);
        end

        // Load-use stall coinciding with flush: flush wins and squashes both young slots.
        rf1  = 32'h100;
        rf2  = 32'h200;
        resA = {32'h44, 32'h33};
        repeat (3) begin
            @(negedge clk);
            issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        issue(1'b1, 5'd12, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 check("flush pre stall", {31'd0, stallA}, 32'd0);
        @(negedge clk);
        issue(1'b1, 5'd13, 1'b0, 5'd12, 5'd0, 1'b1, 1'b0);
        flush = 1'b1;
        #1 check("flush wins stall", {31'd0, stallA}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        issue(1'b1, 5'd14, 1'b0, 5'd12, 5'd13, 1'b1, 1'b1);
        #1;
        check("flush pipe0 valid", {31'd0, dutA.pipeQ[0].valid}, 32'd0);
        check("flush pipe1 valid", {31'd0, dutA.pipeQ[1].valid}, 32'd0);
        @(negedge clk);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("flush no fwd sel1", {30'd0, sel1A}, 32'd0);
        check("flush no fwd op1", op1A, 32'h100);
        check("flush no fwd sel2", {30'd0, sel2A}, 32'd0);

        // Reset while a producer is in flight drops it.
        @(negedge clk);
        issue(1'b1, 5'd20, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 5'd21, 1'b0, 5'd20, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("reset drop sel1", {30'd0, sel1A}, 32'd0);
        check("reset drop op1", op1A, 32'h100);

        // Three forwarding stages, load latency 2: two bubbles, then forward from stage 3.
        doReset();
        resB = {32'hBB, 32'h2, 32'h1};
        @(negedge clk);
        issue(1'b1, 5'd5, 1'b1, 5'd1, 5'd0, 1'b1, 1'b0);
        #1 check("ll2 lw stall", {31'd0, stallB}, 32'd0);
        @(negedge clk);
        issue(1'b1, 5'd6, 1'b0, 5'd5, 5'd7, 1'b1, 1'b1);
        #1;
        nStall = 0;
        while (stallB && (nStall < 6)) begin
            nStall++;
            @(negedge clk);
            #1;
        end
        check("ll2 stall cycles", nStall, 32'd2);
        @(negedge clk);
        issue(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check("ll2 sel1", {30'd0, sel1B}, 32'd3);
        check("ll2 op1", op1B, 32'hBB);
        check("ll2 sel2", {30'd0, sel2B}, 32'd0);
        check("ll2 op2", op2B, 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
